// File: rtl/interval_meas_sequencer_pkg.sv
// rtl/interval_meas_sequencer_pkg.sv - shared types and constants for the interval measurement sequencer
package interval_meas_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_SEL,
        S_CAPT,
        S_ACC,
        S_HOLD
    } state_t;

    localparam logic [31:0] SAT_VALUE = 32'h7FFF_FFFF;
    localparam int          ACC_W     = 40;
    localparam int          LANES     = 4;
    localparam int          LANE_W    = $clog2(LANES);

    function automatic logic [LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
        return LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/interval_meas_sequencer_if.sv
// rtl/interval_meas_sequencer_if.sv - control, byte-lane and result handshake bundle
interface interval_meas_if;
    logic        start;
    logic        abort;
    logic        meas_clr_n;
    logic        meas_fix;
    logic [3:0]  read_byte;
    logic [7:0]  byte_in;
    logic [31:0] result;
    logic        result_ovf;
    logic        result_tmo;
    logic        result_valid;
    logic        result_ready;
    logic        busy;

    modport master (
        input  start, abort, meas_fix, byte_in, result_ready,
        output meas_clr_n, read_byte, result, result_ovf, result_tmo, result_valid, busy
    );

    modport slave (
        output start, abort, meas_fix, byte_in, result_ready,
        input  meas_clr_n, read_byte, result, result_ovf, result_tmo, result_valid, busy
    );
endinterface

// File: rtl/interval_meas_sequencer_fix_edge_sync.sv
// rtl/interval_meas_sequencer_fix_edge_sync.sv - 2-FF synchroniser and rising-edge detect for meas_fix
module fix_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_fix,
    output logic o_rise
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_fix;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // A level already high yields no edge, so a stale fix never re-triggers.
    assign o_rise = r_sync & ~r_prev;
endmodule

// File: rtl/interval_meas_sequencer.sv
// rtl/interval_meas_sequencer.sv - arms, captures and averages signed interval samples over a byte-lane bus
module interval_meas_sequencer
    import interval_meas_sequencer_pkg::*;
#(
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 50000000,
    parameter int ARM_CYC     = 4
) (
    input  logic            i_clk_50,
    input  logic            i_rst_n,
    interval_meas_if.master bus
);
    localparam logic [7:0]  ARM_LAST = 8'(ARM_CYC - 1);
    localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYC - 1);
    localparam logic [4:0]  N_AVG    = 5'(1 << AVG_LOG2);

    state_t                   r_state;
    state_t                   w_next;
    logic [7:0]               r_arm_cnt;
    logic [31:0]              r_tmo_cnt;
    logic [LANE_W-1:0]        r_lane;
    logic [31:0]              r_sample;
    logic signed [ACC_W-1:0]  r_acc;
    logic [4:0]               r_cnt;
    logic                     r_ovf;
    logic                     r_tmo;
    logic [31:0]              r_result;
    logic                     r_result_ovf;
    logic                     r_result_tmo;

    logic                     w_fix_rise;
    logic                     w_clr_n;
    logic [LANES-1:0]         w_read_byte;
    logic                     w_sample_sat;
    logic signed [ACC_W-1:0]  w_sext;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic [4:0]               w_cnt_inc;
    logic                     w_last;
    logic                     w_ovf_any;

    fix_edge_sync u_fix_sync (
        .i_clk   (i_clk_50),
        .i_rst_n (i_rst_n),
        .i_fix   (bus.meas_fix),
        .o_rise  (w_fix_rise)
    );

    assign w_sample_sat = (r_sample == SAT_VALUE);
    assign w_sext       = {{(ACC_W-32){r_sample[31]}}, r_sample};
    assign w_acc_sum    = r_acc + w_sext;
    assign w_cnt_inc    = r_cnt + 5'd1;
    assign w_last       = (w_cnt_inc == N_AVG);
    assign w_ovf_any    = r_ovf | w_sample_sat;

    always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_clr_n     = 1'b1;
        w_read_byte = '0;
        case (r_state)
            S_IDLE: if (bus.start) w_next = S_ARM;
            S_ARM: begin
                w_clr_n = 1'b0;
                if (r_arm_cnt == ARM_LAST) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_fix_rise)            w_next = S_SEL;
                else if (r_tmo_cnt == '0)  w_next = S_ACC;
            end
            S_SEL: begin
                w_read_byte = lane_onehot(r_lane);
                w_next      = S_CAPT;
            end
            S_CAPT: begin
                w_read_byte = lane_onehot(r_lane);
                w_next      = (r_lane == LANE_W'(LANES - 1)) ? S_ACC : S_SEL;
            end
            S_ACC:  w_next = w_last ? S_HOLD : S_ARM;
            S_HOLD: if (bus.result_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.abort) w_next = S_IDLE;
    end

    // Datapath is frozen on abort so a partial average never reaches the result registers.
    always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_arm_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_lane       <= '0;
            r_sample     <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_tmo        <= 1'b0;
            r_result     <= '0;
            r_result_ovf <= 1'b0;
            r_result_tmo <= 1'b0;
        end else if (!bus.abort) begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_ovf     <= 1'b0;
                    r_tmo     <= 1'b0;
                    r_arm_cnt <= '0;
                end
                S_ARM: begin
                    r_arm_cnt <= r_arm_cnt + 8'd1;
                    if (r_arm_cnt == ARM_LAST) r_tmo_cnt <= TMO_LOAD;
                end
                S_WAIT: begin
                    if (w_fix_rise) begin
                        r_lane <= '0;
                    end else if (r_tmo_cnt == '0) begin
                        r_tmo    <= 1'b1;
                        r_sample <= SAT_VALUE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 32'd1;
                    end
                end
                S_CAPT: begin
                    r_sample[8*r_lane +: 8] <= bus.byte_in;
                    r_lane                  <= r_lane + LANE_W'(1);
                end
                S_ACC: begin
                    r_acc     <= w_acc_sum;
                    r_cnt     <= w_cnt_inc;
                    r_ovf     <= w_ovf_any;
                    r_arm_cnt <= '0;
                    if (w_last) begin
                        r_result     <= (w_ovf_any | r_tmo) ? SAT_VALUE : 32'(w_acc_sum >>> AVG_LOG2);
                        r_result_ovf <= w_ovf_any;
                        r_result_tmo <= r_tmo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.meas_clr_n   = w_clr_n;
    assign bus.read_byte    = w_read_byte;
    assign bus.result       = r_result;
    assign bus.result_ovf   = r_result_ovf;
    assign bus.result_tmo   = r_result_tmo;
    assign bus.result_valid = (r_state == S_HOLD);
    assign bus.busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_interval_meas_sequencer.sv
// tb/tb_interval_meas_sequencer.sv - directed self-checking bench for interval_meas_sequencer
module tb_interval_meas_sequencer;

    localparam logic [31:0] SAT = 32'h7FFF_FFFF;

    logic clk = 1'b0;
    always #10 clk = ~clk;
    logic rst_n;

    interval_meas_if ifa ();
    interval_meas_if ifb ();

    logic        start [2];
    logic        abort [2];
    logic        fix   [2];
    logic        ready [2];
    logic [31:0] samp  [2];
    logic        clr   [2];
    logic [3:0]  rb    [2];
    logic [31:0] res   [2];
    logic        ovf   [2];
    logic        tmo   [2];
    logic        rv    [2];
    logic        busy  [2];

    function automatic logic [7:0] lane_pick(input logic [3:0] sel, input logic [31:0] s);
        case (sel)
            4'b0001: return s[7:0];
            4'b0010: return s[15:8];
            4'b0100: return s[23:16];
            4'b1000: return s[31:24];
            default: return 8'h00;
        endcase
    endfunction

    assign ifa.start = start[0];  assign ifb.start = start[1];
    assign ifa.abort = abort[0];  assign ifb.abort = abort[1];
    assign ifa.meas_fix = fix[0]; assign ifb.meas_fix = fix[1];
    assign ifa.result_ready = ready[0]; assign ifb.result_ready = ready[1];
    assign ifa.byte_in = lane_pick(ifa.read_byte, samp[0]);
    assign ifb.byte_in = lane_pick(ifb.read_byte, samp[1]);
    assign clr[0] = ifa.meas_clr_n;  assign clr[1] = ifb.meas_clr_n;
    assign rb[0] = ifa.read_byte;    assign rb[1] = ifb.read_byte;
    assign res[0] = ifa.result;      assign res[1] = ifb.result;
    assign ovf[0] = ifa.result_ovf;  assign ovf[1] = ifb.result_ovf;
    assign tmo[0] = ifa.result_tmo;  assign tmo[1] = ifb.result_tmo;
    assign rv[0] = ifa.result_valid; assign rv[1] = ifb.result_valid;
    assign busy[0] = ifa.busy;       assign busy[1] = ifb.busy;

    interval_meas_sequencer #(.AVG_LOG2(0), .TIMEOUT_CYC(1000), .ARM_CYC(4)) u_dut_a (
        .i_clk_50 (clk),
        .i_rst_n  (rst_n),
        .bus      (ifa)
    );

    interval_meas_sequencer #(.AVG_LOG2(2), .TIMEOUT_CYC(1000), .ARM_CYC(4)) u_dut_b (
        .i_clk_50 (clk),
        .i_rst_n  (rst_n),
        .bus      (ifb)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        int              d;
        logic [31:0]     s [4];
        logic [31:0]     exp_res;
        logic            exp_ovf;
        logic            exp_tmo;
    } vec_t;

    vec_t vecs [8];

    task automatic set_vec(input int i, input int d, input logic [31:0] s0, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] s3,
                           input logic [31:0] r, input logic o, input logic t);
        vecs[i].d = d;
        vecs[i].s[0] = s0; vecs[i].s[1] = s1; vecs[i].s[2] = s2; vecs[i].s[3] = s3;
        vecs[i].exp_res = r; vecs[i].exp_ovf = o; vecs[i].exp_tmo = t;
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_clr(input int d, input logic lvl);
        int n = 0;
        while (clr[d] !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (clr[d] !== lvl) chk($sformatf("wait_clr%0d_d%0d", lvl, d), {31'b0, clr[d]}, {31'b0, lvl});
    endtask

    task automatic wait_rv(input int d);
        int n = 0;
        while (rv[d] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (rv[d] !== 1'b1) chk($sformatf("wait_valid_d%0d", d), {31'b0, rv[d]}, 32'd1);
    endtask

    // Present one sample on the byte-lane model and strobe fix once the DUT is waiting.
    task automatic do_sample(input int d, input logic [31:0] v);
        samp[d] = v;
        wait_clr(d, 1'b0);
        wait_clr(d, 1'b1);
        repeat (5) @(negedge clk);
        fix[d] = 1'b1;
        repeat (3) @(negedge clk);
        fix[d] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic finish_result(input string tag, input int d, input logic [31:0] er,
                                 input logic eo, input logic et);
        wait_rv(d);
        chk({tag, "_result"}, res[d], er);
        chk({tag, "_ovf"}, {31'b0, ovf[d]}, {31'b0, eo});
        chk({tag, "_tmo"}, {31'b0, tmo[d]}, {31'b0, et});
        ready[d] = 1'b1;
        @(negedge clk);
        ready[d] = 1'b0;
        chk({tag, "_busy_after_ready"}, {31'b0, busy[d]}, 32'd0);
        chk({tag, "_valid_after_ready"}, {31'b0, rv[d]}, 32'd0);
    endtask

    logic [3:0] exp_rb [13];
    logic [31:0] held;

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 0; abort[d] = 0; fix[d] = 0; ready[d] = 0; samp[d] = '0;
        end
        rst_n = 1'b0;
        set_vec(0, 0, 32'h12345678, 0, 0, 0, 32'h12345678, 0, 0);
        set_vec(1, 1, 32'd10, 32'd11, 32'd12, 32'hFFFFFFFF, 32'd8, 0, 0);
        set_vec(2, 1, -32'sd3, -32'sd3, -32'sd3, -32'sd4, 32'hFFFFFFFC, 0, 0);
        set_vec(3, 1, 32'd5, SAT, 32'd7, 32'd1, SAT, 1, 0);
        set_vec(4, 0, 32'h80000000, 0, 0, 0, 32'h80000000, 0, 0);
        set_vec(5, 1, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 0, 0);
        set_vec(6, 1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 0, 0);
        set_vec(7, 0, 32'h7FFFFFFE, 0, 0, 0, 32'h7FFFFFFE, 0, 0);
        exp_rb = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h0, 4'h0};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_clr_n_d%0d", d), {31'b0, clr[d]}, 32'd1);
            chk($sformatf("rst_read_byte_d%0d", d), {28'b0, rb[d]}, 32'd0);
            chk($sformatf("rst_result_d%0d", d), res[d], 32'd0);
            chk($sformatf("rst_ovf_d%0d", d), {31'b0, ovf[d]}, 32'd0);
            chk($sformatf("rst_tmo_d%0d", d), {31'b0, tmo[d]}, 32'd0);
            chk($sformatf("rst_valid_d%0d", d), {31'b0, rv[d]}, 32'd0);
            chk($sformatf("rst_busy_d%0d", d), {31'b0, busy[d]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Latency and lane order: fix raised 100 cycles into WAIT, followed edge by edge.
        begin
            int n = 0;
            samp[0] = 32'h12345678;
            pulse_start(0);
            chk("busy_after_start", {31'b0, busy[0]}, 32'd1);
            wait_clr(0, 1'b0);
            while (clr[0] === 1'b0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("arm_len", n, 32'd4);
            repeat (99) @(negedge clk);
            fix[0] = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (k == 3) fix[0] = 1'b0;
                chk($sformatf("lat_rb_k%0d", k), {28'b0, rb[0]}, {28'b0, exp_rb[k]});
                chk($sformatf("lat_valid_k%0d", k), {31'b0, rv[0]}, (k == 12) ? 32'd1 : 32'd0);
            end
            finish_result("lat", 0, 32'h12345678, 1'b0, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            pulse_start(vecs[i].d);
            for (int j = 0; j < ((vecs[i].d == 0) ? 1 : 4); j++) do_sample(vecs[i].d, vecs[i].s[j]);
            finish_result($sformatf("vec%0d", i), vecs[i].d, vecs[i].exp_res, vecs[i].exp_ovf, vecs[i].exp_tmo);
        end

        // Timeout: WAIT spans 1000 cycles, then ACC, then HOLD.
        begin
            int n = 1;
            pulse_start(0);
            wait_clr(0, 1'b0);
            wait_clr(0, 1'b1);
            while (rv[0] !== 1'b1 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk("tmo_exit_cycles", n, 32'd1002);
            finish_result("tmo", 0, SAT, 1'b1, 1'b1);
        end

        // Consumer stall in HOLD with a stray start.
        pulse_start(1);
        do_sample(1, 32'd10); do_sample(1, 32'd11); do_sample(1, 32'd12); do_sample(1, 32'hFFFFFFFF);
        wait_rv(1);
        held = res[1];
        chk("hold_result", held, 32'd8);
        for (int i = 0; i < 50; i++) begin
            start[1] = (i == 10);
            @(negedge clk);
            chk($sformatf("hold_valid_%0d", i), {31'b0, rv[1]}, 32'd1);
            chk($sformatf("hold_stable_%0d", i), res[1], 32'd8);
        end
        start[1] = 1'b0;
        ready[1] = 1'b1;
        @(negedge clk);
        ready[1] = 1'b0;
        chk("hold_busy_drop", {31'b0, busy[1]}, 32'd0);
        repeat (5) @(negedge clk);
        chk("hold_start_ignored", {31'b0, busy[1]}, 32'd0);
        chk("hold_result_kept", res[1], 32'd8);

        // fix already high when WAIT is entered must not count as an edge.
        fix[0] = 1'b1;
        samp[0] = 32'h0000BEEF;
        pulse_start(0);
        wait_clr(0, 1'b0);
        wait_clr(0, 1'b1);
        repeat (20) @(negedge clk);
        chk("fixhigh_no_read", {28'b0, rb[0]}, 32'd0);
        chk("fixhigh_busy", {31'b0, busy[0]}, 32'd1);
        fix[0] = 1'b0;
        repeat (3) @(negedge clk);
        fix[0] = 1'b1;
        repeat (3) @(negedge clk);
        fix[0] = 1'b0;
        finish_result("fixhigh", 0, 32'h0000BEEF, 1'b0, 1'b0);

        // start and abort together in IDLE.
        start[1] = 1'b1; abort[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0; abort[1] = 1'b0;
        chk("sa_busy", {31'b0, busy[1]}, 32'd0);
        repeat (3) @(negedge clk);
        chk("sa_clr_n", {31'b0, clr[1]}, 32'd1);
        chk("sa_busy_later", {31'b0, busy[1]}, 32'd0);

        // Abort during lane-2 capture.
        begin
            int n = 0;
            samp[1] = 32'hA5A5A5A5;
            pulse_start(1);
            wait_clr(1, 1'b0);
            wait_clr(1, 1'b1);
            repeat (5) @(negedge clk);
            fix[1] = 1'b1;
            while (rb[1] !== 4'h4 && n < 100) begin
                @(negedge clk);
                n++;
                if (n == 3) fix[1] = 1'b0;
            end
            fix[1] = 1'b0;
            @(negedge clk);
            chk("abort_in_capt_rb", {28'b0, rb[1]}, 32'h4);
            abort[1] = 1'b1;
            @(negedge clk);
            abort[1] = 1'b0;
            chk("abort_rb", {28'b0, rb[1]}, 32'd0);
            chk("abort_clr_n", {31'b0, clr[1]}, 32'd1);
            chk("abort_valid", {31'b0, rv[1]}, 32'd0);
            chk("abort_busy", {31'b0, busy[1]}, 32'd0);
            chk("abort_result_kept", res[1], 32'd8);
        end

        // Asynchronous reset while waiting for fix.
        pulse_start(1);
        wait_clr(1, 1'b0);
        wait_clr(1, 1'b1);
        repeat (3) @(negedge clk);
        chk("prerst_busy", {31'b0, busy[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy[1]}, 32'd0);
        chk("arst_rb", {28'b0, rb[1]}, 32'd0);
        chk("arst_clr_n", {31'b0, clr[1]}, 32'd1);
        chk("arst_valid", {31'b0, rv[1]}, 32'd0);
        chk("arst_result", res[1], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        pulse_start(1);
        do_sample(1, 32'd100); do_sample(1, 32'd200); do_sample(1, 32'd300); do_sample(1, 32'd403);
        finish_result("clean", 1, 32'd250, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interval_meas_sequencer.md
Name: interval_meas_sequencer

Overview:
Sequences the interval-measurement datapath on the 50 MHz domain. On each start it arms a measurement and waits for the datapath's fix strobe or a timeout. It then reads the 32-bit signed interval over the shared 8-bit byte-lane bus and averages 2^AVG_LOG2 measurements. The averaged result goes to the host-side register block through a valid/ready handshake.

Parameters:
AVG_LOG2, 2, log2 of measurements averaged per result (0..4)
TIMEOUT_CYC, 50000000, clk_50 cycles to wait for fix before declaring timeout
ARM_CYC, 4, cycles meas_clr_n is held low to clear the counters

Ports:
clk_50  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begin a result (ignored when busy)
abort  in  1  single-cycle pulse; return to IDLE, no result produced
meas_clr_n  out  1  active-low clear/arm to the interval datapath
meas_fix  in  1  level/pulse from datapath: new interval latched (synchronised here, 2 FF)
read_byte  out  4  one-hot byte-lane select to datapath; 4'b0000 when idle
byte_in  in  8  byte-lane read data
result  out  32  signed averaged interval; 32'h7FFFFFFF on overflow/timeout
result_ovf  out  1  any sample saturated (== 32'h7FFFFFFF)
result_tmo  out  1  timeout occurred during this result
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
busy  out  1  high from start accepted until result accepted or abort

Behaviour:
- Reset values: meas_clr_n=1, read_byte=0, result=0, result_ovf=0, result_tmo=0, result_valid=0, busy=0, state=IDLE.
- States: IDLE, ARM, WAIT, SEL, CAPT, ACC, HOLD.
- IDLE: start -> clear accumulator (40-bit signed), sample counter, ovf/tmo sticky flags -> ARM; busy=1.
- ARM: meas_clr_n=0 for ARM_CYC cycles -> WAIT. The timeout counter is loaded with TIMEOUT_CYC-1.
- WAIT: rising edge of synchronised meas_fix -> SEL with lane=0. If the counter reaches 0 first: set tmo, force the sample to 32'h7FFFFFFF -> ACC.
- SEL: drive read_byte = 1<<lane for one cycle -> CAPT. read_byte stays driven in CAPT.
- CAPT: byte_in is registered into sample[8*lane+:8]. lane<3: lane++ -> SEL. lane==3 -> ACC.
- Per-byte cost is 2 cycles; fix-to-ACC latency is 8 cycles after synchroniser.
- ACC: if sample==32'h7FFFFFFF, set ovf. acc += sign-extended sample. count++.
  - count == 2^AVG_LOG2 -> compute result -> HOLD.
  - Otherwise -> ARM.
- Result computation: if ovf|tmo, result=32'h7FFFFFFF; else result = acc >>> AVG_LOG2 (arithmetic shift, truncation toward -inf), low 32 bits.
- HOLD: result_valid=1 and result/flags stable. result_valid & result_ready -> IDLE, busy=0, result_valid=0 next cycle. result keeps its last value.
- Timeout does not stop averaging: remaining samples still run, but the final result is saturated.
- abort in any state: next state IDLE, meas_clr_n=1, read_byte=0, result_valid=0, no partial result. abort wins over a simultaneous fix or ready.
- start while busy: ignored. start and abort in the same cycle in IDLE: abort wins, stay IDLE.
- meas_fix already high on WAIT entry: not a rising edge, so keep waiting.
- Reset mid-operation: all outputs return to reset values asynchronously.
- Invariants:
  - read_byte is at most one-hot and is zero outside SEL/CAPT.
  - meas_clr_n is low only in ARM.

Decomposition:
- Shared package holds:
  - state encoding
  - SAT_VALUE = 32'h7FFFFFFF
  - ACC_W = 32+4 rounded to 40
  - LANES = 4
- One natural sub-module: fix_edge_sync (2-FF synchroniser plus rising-edge detector for meas_fix).

Test Plan:
- AVG_LOG2=0, fix after 100 cycles, bytes 78,56,34,12 -> result=32'h12345678 and valid; fix-to-valid latency is as specified; read_byte sequence 1,2,4,8.
- AVG_LOG2=2, samples 10,11,12,-1 -> sum 32, result=8; then samples -3,-3,-3,-4 -> result=-4 (arithmetic floor).
- One of 4 samples = 32'h7FFFFFFF -> result=32'h7FFFFFFF, result_ovf=1, result_tmo=0.
- TIMEOUT_CYC=1000, no fix -> WAIT exits after exactly 1000 cycles; AVG_LOG2=0 gives result=32'h7FFFFFFF, result_tmo=1.
- result_ready held low 50 cycles -> valid and result stable; a start during HOLD is ignored; ready=1 -> busy drops the next cycle.
- abort during CAPT lane 2, then rst_n pulse during WAIT -> read_byte=0, meas_clr_n=1, valid=0 immediately; a new start afterwards yields a clean result.
